// File: rtl/uart_rx_packet_ctrl.sv
// Purpose: turns the UART receiver byte stream (SOF, LEN, payload, CHK) into checked packets on a valid/ready stream.
// Latency: pkt_valid rises the cycle after the CHK byte; one payload byte per cycle while pkt_ready is high.
// Backpressure: pkt_ready stalls the payload stream; rx bytes arriving while sending are dropped and flagged as overrun.
// Ports: clk/rst_n (async active-low); rx_data/rx_valid byte input; pkt_data/pkt_valid/pkt_last/pkt_ready payload stream;
//        pkt_ok/err_len/err_chk/err_timeout/overrun one-cycle status pulses; busy while a frame is in progress.
module uart_rx_packet_ctrl #(
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 1000,
    parameter logic [7:0] SOF_BYTE       = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    output logic       pkt_last,
    input  logic       pkt_ready,
    output logic       pkt_ok,
    output logic       err_len,
    output logic       err_chk,
    output logic       err_timeout,
    output logic       overrun,
    output logic       busy
);

    localparam int               IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int               TMO_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_SEND
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       len, chk, wr_idx, rd_idx;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       pay_buf [MAX_LEN];

    logic ok_nxt, err_len_nxt, err_chk_nxt, err_tmo_nxt, ovr_nxt;
    logic mid_frame, tmo_exp;

    // The timer only runs between SOF and CHK; a byte on the expiry cycle wins.
    assign mid_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
    assign tmo_exp   = !rx_valid && (tmo_cnt == TMO_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and pulse decode
    always_comb begin
        state_nxt   = state;
        ok_nxt      = 1'b0;
        err_len_nxt = 1'b0;
        err_chk_nxt = 1'b0;
        err_tmo_nxt = 1'b0;
        ovr_nxt     = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_valid && rx_data == SOF_BYTE) state_nxt = S_LEN;
            end
            S_LEN: begin
                if (rx_valid) begin
                    if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                        err_len_nxt = 1'b1;
                        state_nxt   = S_IDLE;
                    end else begin
                        state_nxt = S_PAYLOAD;
                    end
                end else if (tmo_exp) begin
                    err_tmo_nxt = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (rx_valid) begin
                    if (wr_idx == len - 8'd1) state_nxt = S_CHK;
                end else if (tmo_exp) begin
                    err_tmo_nxt = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            S_CHK: begin
                if (rx_valid) begin
                    if (rx_data == chk) begin
                        ok_nxt    = 1'b1;
                        state_nxt = S_SEND;
                    end else begin
                        err_chk_nxt = 1'b1;
                        state_nxt   = S_IDLE;
                    end
                end else if (tmo_exp) begin
                    err_tmo_nxt = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            S_SEND: begin
                // No receive buffering while draining: the byte is lost, SOF included.
                if (rx_valid) ovr_nxt = 1'b1;
                if (pkt_ready && pkt_last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy      = (state != S_IDLE);
        pkt_valid = (state == S_SEND);
        pkt_data  = pkt_valid ? pay_buf[rd_idx[IDX_W-1:0]] : 8'd0;
        pkt_last  = pkt_valid && (rd_idx == len - 8'd1);
    end

    // Frame bookkeeping, timer and registered status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len         <= 8'd0;
            chk         <= 8'd0;
            wr_idx      <= 8'd0;
            rd_idx      <= 8'd0;
            tmo_cnt     <= '0;
            pkt_ok      <= 1'b0;
            err_len     <= 1'b0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            pkt_ok      <= ok_nxt;
            err_len     <= err_len_nxt;
            err_chk     <= err_chk_nxt;
            err_timeout <= err_tmo_nxt;
            overrun     <= ovr_nxt;

            if (!mid_frame || rx_valid || state_nxt != state) tmo_cnt <= '0;
            else                                               tmo_cnt <= tmo_cnt + TMO_W'(1);

            case (state)
                S_LEN: if (rx_valid) begin
                    // Harmless on a rejected length: the frame is abandoned anyway.
                    len    <= rx_data;
                    chk    <= rx_data;
                    wr_idx <= 8'd0;
                end
                S_PAYLOAD: if (rx_valid) begin
                    chk    <= chk ^ rx_data;
                    wr_idx <= wr_idx + 8'd1;
                end
                S_CHK: if (rx_valid) rd_idx <= 8'd0;
                S_SEND: if (pkt_valid && pkt_ready) rd_idx <= rd_idx + 8'd1;
                default: ;
            endcase
        end
    end

    // Payload storage needs no reset; it is only read after being written.
    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD && rx_valid) pay_buf[wr_idx[IDX_W-1:0]] <= rx_data;
    end

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Purpose: directed checks of uart_rx_packet_ctrl framing, checksum, length, timeout, backpressure, overrun and reset.
// Latency: each step drives inputs just after a rising edge and observes outputs 1 time unit after the next one.
// Backpressure: pkt_ready is driven per step from the vector table and the hand-written sequences.
module tb_uart_rx_packet_ctrl;

    localparam int TMO = 64;

    localparam logic [4:0] P_NONE = 5'b00000;
    localparam logic [4:0] P_OK   = 5'b10000;
    localparam logic [4:0] P_LEN  = 5'b01000;
    localparam logic [4:0] P_CHK  = 5'b00100;
    localparam logic [4:0] P_TMO  = 5'b00010;
    localparam logic [4:0] P_OVR  = 5'b00001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic       pkt_ready = 1'b0;
    logic [7:0] pkt_data;
    logic       pkt_valid, pkt_last, pkt_ok, err_len, err_chk, err_timeout, overrun, busy;

    int checks   = 0;
    int failures = 0;

    uart_rx_packet_ctrl #(
        .MAX_LEN       (16),
        .TIMEOUT_CYCLES(TMO),
        .SOF_BYTE      (8'hA5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .pkt_data   (pkt_data),
        .pkt_valid  (pkt_valid),
        .pkt_last   (pkt_last),
        .pkt_ready  (pkt_ready),
        .pkt_ok     (pkt_ok),
        .err_len    (err_len),
        .err_chk    (err_chk),
        .err_timeout(err_timeout),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // {busy, pkt_valid, pkt_last, pkt_data, pkt_ok, err_len, err_chk, err_timeout, overrun}
    logic [15:0] obs;
    assign obs = {busy, pkt_valid, pkt_last, pkt_data, pkt_ok, err_len, err_chk, err_timeout, overrun};

    typedef struct {
        logic        vld;
        logic [7:0]  dat;
        logic        rdy;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] ex(input logic b, input logic pv, input logic pl,
                                       input logic [7:0] pd, input logic [4:0] p);
        return {b, pv, pl, pd, p};
    endfunction

    function automatic void add(input logic v, input logic [7:0] d, input logic r, input logic [15:0] e);
        vec_t t;
        t.vld = v;
        t.dat = d;
        t.rdy = r;
        t.exp = e;
        vecs.push_back(t);
    endfunction

    // pkt_data/pkt_last only matter while pkt_valid is expected, except for the strict reset check.
    task automatic check(input string name, input logic [15:0] want, input logic strict);
        logic [15:0] mask;
        mask = (want[14] || strict) ? 16'hFFFF : 16'hC01F;
        checks++;
        if ((obs & mask) !== (want & mask)) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, obs & mask, want & mask);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        rx_valid  = v;
        rx_data   = d;
        pkt_ready = r;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] B, I;

    initial begin
        B = ex(1'b1, 1'b0, 1'b0, 8'h00, P_NONE);
        I = ex(1'b0, 1'b0, 1'b0, 8'h00, P_NONE);

        // Good frame with leading junk, ready held high
        add(1, 8'h00, 1, I);
        add(1, 8'h7F, 1, I);
        add(1, 8'hA5, 1, B);
        add(1, 8'h03, 1, B);
        add(1, 8'h11, 1, B);
        add(1, 8'h22, 1, B);
        add(1, 8'h33, 1, B);
        add(1, 8'h03, 1, ex(1, 1, 0, 8'h11, P_OK));
        add(0, 8'h00, 1, ex(1, 1, 0, 8'h22, P_NONE));
        add(0, 8'h00, 1, ex(1, 1, 1, 8'h33, P_NONE));
        add(0, 8'h00, 1, I);
        // Bad checksum, then a good frame
        add(1, 8'hA5, 1, B);
        add(1, 8'h03, 1, B);
        add(1, 8'h11, 1, B);
        add(1, 8'h22, 1, B);
        add(1, 8'h33, 1, B);
        add(1, 8'h04, 1, ex(0, 0, 0, 8'h00, P_CHK));
        add(0, 8'h00, 1, I);
        add(1, 8'hA5, 1, B);
        add(1, 8'h03, 1, B);
        add(1, 8'h11, 1, B);
        add(1, 8'h22, 1, B);
        add(1, 8'h33, 1, B);
        add(1, 8'h03, 1, ex(1, 1, 0, 8'h11, P_OK));
        add(0, 8'h00, 1, ex(1, 1, 0, 8'h22, P_NONE));
        add(0, 8'h00, 1, ex(1, 1, 1, 8'h33, P_NONE));
        add(0, 8'h00, 1, I);
        // Length bounds: zero and MAX_LEN+1
        add(1, 8'hA5, 1, B);
        add(1, 8'h00, 1, ex(0, 0, 0, 8'h00, P_LEN));
        add(1, 8'hA5, 1, B);
        add(1, 8'h11, 1, ex(0, 0, 0, 8'h00, P_LEN));
        add(0, 8'h00, 1, I);
        // Backpressure 1,0,0,1,0,1 with a SOF injected while stalled
        add(1, 8'hA5, 0, B);
        add(1, 8'h03, 0, B);
        add(1, 8'h11, 0, B);
        add(1, 8'h22, 0, B);
        add(1, 8'h33, 0, B);
        add(1, 8'h03, 0, ex(1, 1, 0, 8'h11, P_OK));
        add(0, 8'h00, 1, ex(1, 1, 0, 8'h22, P_NONE));
        add(0, 8'h00, 0, ex(1, 1, 0, 8'h22, P_NONE));
        add(1, 8'hA5, 0, ex(1, 1, 0, 8'h22, P_OVR));
        add(0, 8'h00, 1, ex(1, 1, 1, 8'h33, P_NONE));
        add(0, 8'h00, 0, ex(1, 1, 1, 8'h33, P_NONE));
        add(0, 8'h00, 1, I);
        add(0, 8'h00, 1, I);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 16'h0000, 1'b1);
        rst_n = 1'b1;
        step(0, 8'h00, 1);
        check("idle_after_reset", I, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].vld, vecs[i].dat, vecs[i].rdy);
            check($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
        end

        // Full-length frame: bytes 01..10, XOR of LEN and payload is 00
        step(1, 8'hA5, 1);
        step(1, 8'h10, 1);
        for (int i = 1; i <= 16; i++) step(1, 8'(i), 1);
        check("max_len_in_chk", B, 1'b0);
        step(1, 8'h00, 1);
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("max_len_byte%0d", i),
                  ex(1, 1, (i == 16), 8'(i), (i == 1) ? P_OK : P_NONE), 1'b0);
            step(0, 8'h00, 1);
        end
        check("max_len_done", I, 1'b0);

        // Timeout: silence after a payload byte
        step(1, 8'hA5, 1);
        step(1, 8'h02, 1);
        step(1, 8'h11, 1);
        for (int k = 1; k <= TMO + 1; k++) begin
            step(0, 8'h00, 1);
            if (k >= TMO - 1)
                check($sformatf("tmo_k%0d", k),
                      ex((k < TMO), 0, 0, 8'h00, (k == TMO) ? P_TMO : P_NONE), 1'b0);
        end

        // A byte on the expiry cycle beats the timeout
        step(1, 8'hA5, 1);
        step(1, 8'h02, 1);
        step(1, 8'h11, 1);
        for (int k = 1; k < TMO; k++) step(0, 8'h00, 1);
        step(1, 8'h22, 1);
        check("tmo_byte_wins", B, 1'b0);
        step(1, 8'h31, 1);
        check("tmo_win_ok", ex(1, 1, 0, 8'h11, P_OK), 1'b0);
        step(0, 8'h00, 1);
        check("tmo_win_last", ex(1, 1, 1, 8'h22, P_NONE), 1'b0);
        step(0, 8'h00, 1);
        check("tmo_win_idle", I, 1'b0);

        // Asynchronous reset mid-frame
        step(1, 8'hA5, 1);
        step(1, 8'h03, 1);
        step(1, 8'h11, 1);
        check("pre_reset_busy", B, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_frame_reset", 16'h0000, 1'b1);
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        check("held_reset", 16'h0000, 1'b1);
        rst_n = 1'b1;
        step(1, 8'hA5, 1);
        step(1, 8'h01, 1);
        step(1, 8'h55, 1);
        step(1, 8'h54, 1);
        check("post_reset_frame", ex(1, 1, 1, 8'h55, P_OK), 1'b0);
        step(0, 8'h00, 1);
        check("post_reset_idle", I, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
